tdm_demux2: RTL



---
 rtl/tdm_demux2.sv | 55 +++++
 1 files changed

// File: rtl/tdm_demux2.sv
// tdm_demux2: two-channel TDM demultiplexer with A/B pairing FSM and sticky order error
module tdm_demux2 #(
    parameter int WIDTH      = 4,
    parameter bit AUTO_START = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             E,
    input  logic             S,
    input  logic             auto,
    input  logic [WIDTH-1:0] Y,
    input  logic             clr_err,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             a_vld,
    output logic             b_vld,
    output logic             pair_vld,
    output logic             seq_err,
    output logic             next_ch
);
    localparam logic [1:0] EMPTY  = 2'd0;
    localparam logic [1:0] HAVE_A = 2'd1;
    localparam logic [1:0] HAVE_B = 2'd2;
    logic [1:0] r_st;
    logic       w_ch;
    logic       w_rep;
    logic       w_pair;
    assign w_ch   = auto ? next_ch : S;
    assign w_rep  = E && ((r_st == HAVE_A && !w_ch) || (r_st == HAVE_B && w_ch));
    assign w_pair = E && ((r_st == HAVE_A && w_ch) || (r_st == HAVE_B && !w_ch));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            A        <= '0;
            B        <= '0;
            a_vld    <= 1'b0;
            b_vld    <= 1'b0;
            pair_vld <= 1'b0;
            seq_err  <= 1'b0;
            next_ch  <= AUTO_START;
            r_st     <= EMPTY;
        end else begin
            a_vld    <= E & ~w_ch;
            b_vld    <= E & w_ch;
            pair_vld <= w_pair;
            // set has priority over clear
            seq_err  <= w_rep | (seq_err & ~clr_err);
            if (E) begin
                if (w_ch) B <= Y;
                else      A <= Y;
                next_ch <= ~w_ch;
                r_st    <= w_pair ? EMPTY : (w_ch ? HAVE_B : HAVE_A);
            end
        end
    end
endmodule
